// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: converts decode hazard codes and MUL/DIV issue into
// PC/IF-ID hold plus ID/EX bubble, with a wait-state watchdog and a stall counter.
module hazard_sequencer #(
   parameter int unsigned TIMEOUT   = 255,
   parameter int unsigned CNT_WIDTH = 16
) (
   input  logic                 brq_clk,
   input  logic                 brq_rst,
   input  logic [1:0]           idu_check_stall,
   input  logic                 idu_flush,
   input  logic                 ldst_resume,
   input  logic                 mdu_start,
   input  logic                 mdu_done,
   output logic                 pc_hold,
   output logic                 ifid_hold,
   output logic                 idex_bubble,
   output logic [1:0]           seq_state,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      MDU_WAIT = 2'b10,
      ILLEGAL  = 2'b11
   } state_e;

   localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

   state_e                 state_q, state_d;
   logic [15:0]            wait_cnt_q, wait_cnt_d;
   logic [CNT_WIDTH-1:0]   stall_cnt_q, stall_cnt_d;
   logic                   timeout_err_q, timeout_err_d;
   logic                   hold_raw;
   logic                   hold;

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      wait_cnt_d    = wait_cnt_q;
      timeout_err_d = timeout_err_q;
      hold_raw      = 1'b0;
      case (state_q)
         RUN: begin
            if (!idu_flush) begin
               if (idu_check_stall == 2'b01) begin
                  hold_raw = 1'b1;
               end else if (idu_check_stall == 2'b10) begin
                  hold_raw = 1'b1;
                  if (!ldst_resume) begin
                     state_d    = MEM_WAIT;
                     wait_cnt_d = '0;
                  end
               end else if (mdu_start) begin
                  hold_raw   = 1'b1;
                  state_d    = MDU_WAIT;
                  wait_cnt_d = '0;
               end
            end
         end
         MEM_WAIT: begin
            if (ldst_resume) begin
               state_d = RUN;
            end else if (wait_cnt_q == WD_LAST) begin
               state_d       = RUN;
               timeout_err_d = 1'b1;
            end else begin
               hold_raw   = 1'b1;
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         MDU_WAIT: begin
            if (mdu_done) begin
               state_d = RUN;
            end else if (wait_cnt_q == WD_LAST) begin
               state_d       = RUN;
               timeout_err_d = 1'b1;
            end else begin
               hold_raw   = 1'b1;
               wait_cnt_d = wait_cnt_q + 16'd1;
            end
         end
         default: state_d = RUN;
      endcase

      hold        = hold_raw & ~brq_rst;
      stall_cnt_d = (hold && (stall_cnt_q != '1)) ? stall_cnt_q + CNT_WIDTH'(1) : stall_cnt_q;
   end

   // NOTE: sequential state is updated with non-blocking assignments only.
   always_ff @(posedge brq_clk) begin
      if (brq_rst) begin
         state_q       <= RUN;
         wait_cnt_q    <= '0;
         stall_cnt_q   <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         wait_cnt_q    <= wait_cnt_d;
         stall_cnt_q   <= stall_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end

   assign pc_hold     = hold;
   assign ifid_hold   = hold;
   assign idex_bubble = hold;
   assign seq_state   = state_q;
   assign stall_cnt   = stall_cnt_q;
   assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// Directed bench for hazard_sequencer: short watchdog / narrow counter instance plus
// a default-parameter instance sharing the same stimulus.
module tb_hazard_sequencer;

   logic        brq_clk = 1'b0;
   logic        brq_rst;
   logic [1:0]  idu_check_stall;
   logic        idu_flush;
   logic        ldst_resume;
   logic        mdu_start;
   logic        mdu_done;

   logic        pc_hold, ifid_hold, idex_bubble, timeout_err;
   logic [1:0]  seq_state;
   logic [3:0]  stall_cnt;

   logic        d_pc_hold, d_ifid_hold, d_idex_bubble, d_timeout_err;
   logic [1:0]  d_seq_state;
   logic [15:0] d_stall_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 brq_clk = ~brq_clk;

   hazard_sequencer #(.TIMEOUT(4), .CNT_WIDTH(4)) u_dut (
      .brq_clk(brq_clk), .brq_rst(brq_rst),
      .idu_check_stall(idu_check_stall), .idu_flush(idu_flush),
      .ldst_resume(ldst_resume), .mdu_start(mdu_start), .mdu_done(mdu_done),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
      .seq_state(seq_state), .stall_cnt(stall_cnt), .timeout_err(timeout_err)
   );

   hazard_sequencer u_dflt (
      .brq_clk(brq_clk), .brq_rst(brq_rst),
      .idu_check_stall(idu_check_stall), .idu_flush(idu_flush),
      .ldst_resume(ldst_resume), .mdu_start(mdu_start), .mdu_done(mdu_done),
      .pc_hold(d_pc_hold), .ifid_hold(d_ifid_hold), .idex_bubble(d_idex_bubble),
      .seq_state(d_seq_state), .stall_cnt(d_stall_cnt), .timeout_err(d_timeout_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_hold(input string tag, input logic exp);
      check(tag, {29'd0, pc_hold, ifid_hold, idex_bubble}, {29'd0, {3{exp}}});
   endtask

   task automatic tick();
      @(posedge brq_clk);
      #1;
   endtask

   task automatic mid();
      #4;
   endtask

   initial begin
      brq_rst = 1'b1; idu_check_stall = 2'b00; idu_flush = 1'b0;
      ldst_resume = 1'b0; mdu_start = 1'b0; mdu_done = 1'b0;

      // Reset: hold forced low even with a pending request
      tick();
      idu_check_stall = 2'b01;
      mid();  check_hold("rst_hold_forced", 1'b0);
      tick();
      check("rst_state", seq_state, 0);
      check("rst_stall", stall_cnt, 0);
      check("rst_err", timeout_err, 0);
      brq_rst = 1'b0;

      // Load-use against EX, evaluated in the first cycle after reset
      mid();  check_hold("ex_hold", 1'b1);
      tick(); idu_check_stall = 2'b00;
      check("ex_state", seq_state, 0);
      check("ex_stall", stall_cnt, 1);
      mid();  check_hold("ex_hold_release", 1'b0);

      // Memory wait, resume three cycles later
      tick(); idu_check_stall = 2'b10;
      mid();  check_hold("mem_hold0", 1'b1);
      tick(); idu_check_stall = 2'b00;
      check("mem_state1", seq_state, 1);
      mid();  check_hold("mem_hold1", 1'b1);
      tick(); check("mem_state2", seq_state, 1);
      mid();  check_hold("mem_hold2", 1'b1);
      tick(); ldst_resume = 1'b1;
      mid();  check_hold("mem_resume_hold", 1'b0);
      tick(); ldst_resume = 1'b0;
      check("mem_exit_state", seq_state, 0);
      check("mem_stall", stall_cnt, 4);

      // Flush masks every request
      idu_flush = 1'b1; idu_check_stall = 2'b10; mdu_start = 1'b1;
      mid();  check_hold("flush_hold", 1'b0);
      tick(); idu_flush = 1'b0; idu_check_stall = 2'b00; mdu_start = 1'b0;
      check("flush_state", seq_state, 0);
      check("flush_stall", stall_cnt, 4);

      // Code 10 with same-cycle resume: one hold, no MEM_WAIT
      idu_check_stall = 2'b10; ldst_resume = 1'b1;
      mid();  check_hold("same_hold", 1'b1);
      tick(); idu_check_stall = 2'b00; ldst_resume = 1'b0;
      check("same_state", seq_state, 0);
      check("same_stall", stall_cnt, 5);

      // MUL/DIV: done ignored in RUN, honoured in MDU_WAIT
      mdu_start = 1'b1; mdu_done = 1'b1;
      mid();  check_hold("mdu_hold0", 1'b1);
      tick(); mdu_start = 1'b0; mdu_done = 1'b0;
      check("mdu_state1", seq_state, 2);
      mid();  check_hold("mdu_hold1", 1'b1);
      tick(); mdu_done = 1'b1;
      mid();  check_hold("mdu_done_hold", 1'b0);
      tick(); mdu_done = 1'b0;
      check("mdu_exit_state", seq_state, 0);
      check("mdu_stall", stall_cnt, 7);

      // Code 01 outranks mdu_start; code 11 behaves as no hazard
      idu_check_stall = 2'b01; mdu_start = 1'b1;
      mid();  check_hold("prio_hold", 1'b1);
      tick(); idu_check_stall = 2'b11; mdu_start = 1'b0;
      check("prio_state", seq_state, 0);
      mid();  check_hold("code11_hold", 1'b0);
      tick(); idu_check_stall = 2'b00;
      check("code11_state", seq_state, 0);
      check("prio_stall", stall_cnt, 8);

      // Resume coinciding with the watchdog limit exits normally
      idu_check_stall = 2'b10;
      mid();  check_hold("wdr_hold0", 1'b1);
      tick(); idu_check_stall = 2'b00;
      tick(); tick();
      check("wdr_state_last", seq_state, 1);
      tick(); ldst_resume = 1'b1;
      mid();  check_hold("wdr_resume_hold", 1'b0);
      tick(); ldst_resume = 1'b0;
      check("wdr_state", seq_state, 0);
      check("wdr_err", timeout_err, 0);
      check("wdr_stall", stall_cnt, 12);

      // Reset in the second MEM_WAIT cycle
      idu_check_stall = 2'b10;
      tick(); idu_check_stall = 2'b00;
      check("rmw_state1", seq_state, 1);
      tick(); brq_rst = 1'b1;
      mid();  check_hold("rmw_hold_in_rst", 1'b0);
      tick();
      check("rmw_state", seq_state, 0);
      check("rmw_stall", stall_cnt, 0);
      check("rmw_err", timeout_err, 0);
      check_hold("rmw_hold", 1'b0);
      brq_rst = 1'b0;

      // Watchdog on MDU_WAIT with TIMEOUT=4
      mdu_start = 1'b1;
      mid();  check_hold("wd_hold0", 1'b1);
      tick(); mdu_start = 1'b0;
      mid();  check_hold("wd_hold1", 1'b1);
      tick(); mid(); check_hold("wd_hold2", 1'b1);
      tick(); mid(); check_hold("wd_hold3", 1'b1);
      tick(); mid(); check_hold("wd_fire_hold", 1'b0);
      check("wd_fire_err_pre", timeout_err, 0);
      tick();
      check("wd_err", timeout_err, 1);
      check("wd_state", seq_state, 0);
      check("wd_stall", stall_cnt, 4);
      mdu_done = 1'b1;
      mid();  check_hold("wd_late_done_hold", 1'b0);
      tick(); mdu_done = 1'b0;
      check("wd_late_state", seq_state, 0);
      check("wd_err_sticky", timeout_err, 1);
      check("wd_late_stall", stall_cnt, 4);

      // Saturation: 20 hold cycles into a 4-bit and a 16-bit counter
      brq_rst = 1'b1;
      tick(); brq_rst = 1'b0;
      check("sat_err_cleared", timeout_err, 0);
      idu_check_stall = 2'b01;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (i == 15) begin
            check("sat_at15", stall_cnt, 15);
            check("dflt_at15", d_stall_cnt, 15);
         end
      end
      idu_check_stall = 2'b00;
      check("sat_at20", stall_cnt, 15);
      check("dflt_at20", d_stall_cnt, 20);
      check("dflt_state", d_seq_state, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
